// File: rtl/clock_time_set.sv
// clock_time_set
// Time-of-day counter with a field-setting front end. Consumes the press
// codes of the add-key analyser (001 single, 010 double, 100 long).
//   Run mode : BCD hh:mm:ss advanced by a CLK_PER_SEC prescaler.
//   Set mode : single press / long-press auto-repeat increment the selected
//              field (no carry), double press rotates min -> hour -> sec.
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   add_select  [2:0] press code, 000 = none
//   set_en      1 = set mode, 0 = run mode
//   hour_bcd    [7:0] BCD 00-23
//   min_bcd     [7:0] BCD 00-59
//   sec_bcd     [7:0] BCD 00-59
//   field_sel   [1:0] 0 run, 1 sec, 2 min, 3 hour
//   sec_pulse   one-cycle pulse on each run-mode second rollover
module clock_time_set #(
  parameter int CLK_PER_SEC   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] add_select,
  input  logic       set_en,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] field_sel,
  output logic       sec_pulse
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_PER_SEC - 1);
  localparam logic [RW-1:0] RPT_TC = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_SEC  = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_HOUR = 2'd3
  } state_t;

  // Limit is checked first so the field never takes a non-BCD value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t        r_state, w_state_nx;
  logic [7:0]    r_hour, r_min, r_sec;
  logic [7:0]    w_hour_nx, w_min_nx, w_sec_nx;
  logic [PW-1:0] r_pre, w_pre_nx;
  logic [RW-1:0] r_rpt, w_rpt_nx;
  logic          r_pulse, w_pulse_nx;
  logic          r_long_act, w_long_act_nx;
  logic [2:0]    r_add_d;
  logic          r_set_en_d;

  logic          w_onehot;
  logic [2:0]    w_rise;
  logic          w_in_set;
  logic          w_single, w_double, w_long_rise, w_long_hold, w_rpt_inc, w_inc;

  // Presses only count in a stable set-mode cycle: a cycle where the mode
  // is changing (entering or leaving) drops the press.
  assign w_onehot    = (add_select == 3'b001) || (add_select == 3'b010) ||
                       (add_select == 3'b100);
  assign w_rise      = add_select & ~r_add_d;
  assign w_in_set    = (r_state != ST_RUN) && set_en && r_set_en_d;
  assign w_single    = w_in_set && w_onehot && w_rise[0];
  assign w_double    = w_in_set && w_onehot && w_rise[1];
  assign w_long_rise = w_in_set && w_onehot && w_rise[2];
  // r_long_act is only ever set by a seen rising edge of bit 2, so a code
  // already held across reset or across entry into set mode never repeats.
  assign w_long_hold = w_in_set && r_long_act && (add_select == 3'b100);
  assign w_rpt_inc   = w_long_hold && (r_rpt == RPT_TC);
  assign w_inc       = w_single || w_long_rise || w_rpt_inc;

  always_comb begin
    w_state_nx    = r_state;
    w_hour_nx     = r_hour;
    w_min_nx      = r_min;
    w_sec_nx      = r_sec;
    w_pre_nx      = '0;
    w_pulse_nx    = 1'b0;
    w_rpt_nx      = '0;
    w_long_act_nx = w_long_rise || (r_long_act && w_long_hold);

    if (w_long_hold)
      w_rpt_nx = (r_rpt == RPT_TC) ? '0 : r_rpt + RW'(1);

    unique case (r_state)
      ST_RUN: begin
        if (set_en) begin
          // Entering set mode wins over a terminal count in the same cycle.
          w_state_nx = ST_SET_MIN;
        end else if (r_pre == PRE_TC) begin
          w_pulse_nx = 1'b1;
          w_sec_nx   = bcd_inc(r_sec, 8'h59);
          if (r_sec == 8'h59) begin
            w_min_nx = bcd_inc(r_min, 8'h59);
            if (r_min == 8'h59)
              w_hour_nx = bcd_inc(r_hour, 8'h23);
          end
        end else begin
          w_pre_nx = r_pre + PW'(1);
        end
      end
      default: begin
        if (!set_en) begin
          w_state_nx = ST_RUN;
        end else if (w_double) begin
          unique case (r_state)
            ST_SET_MIN:  w_state_nx = ST_SET_HOUR;
            ST_SET_HOUR: w_state_nx = ST_SET_SEC;
            default:     w_state_nx = ST_SET_MIN;
          endcase
        end else if (w_inc) begin
          unique case (r_state)
            ST_SET_SEC:  w_sec_nx  = bcd_inc(r_sec, 8'h59);
            ST_SET_MIN:  w_min_nx  = bcd_inc(r_min, 8'h59);
            default:     w_hour_nx = bcd_inc(r_hour, 8'h23);
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_hour     <= 8'h00;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_pre      <= '0;
      r_rpt      <= '0;
      r_pulse    <= 1'b0;
      r_long_act <= 1'b0;
      r_add_d    <= 3'b000;
      r_set_en_d <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_hour     <= w_hour_nx;
      r_min      <= w_min_nx;
      r_sec      <= w_sec_nx;
      r_pre      <= w_pre_nx;
      r_rpt      <= w_rpt_nx;
      r_pulse    <= w_pulse_nx;
      r_long_act <= w_long_act_nx;
      r_add_d    <= add_select;
      r_set_en_d <= set_en;
    end
  end

  assign hour_bcd  = r_hour;
  assign min_bcd   = r_min;
  assign sec_bcd   = r_sec;
  assign field_sel = r_state;
  assign sec_pulse = r_pulse;

endmodule

// File: tb/tb_clock_time_set.sv
// Bench for clock_time_set: a vector table, hand sequences for the long
// runs / wrap / reset-during-press cases, then randomized stimulus, all
// checked against an integer time-of-day reference model.
module tb_clock_time_set;
  localparam int CPS = 10;
  localparam int REP = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] add_select = 3'b000;
  logic       set_en = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] field_sel;
  logic       sec_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_time_set #(.CLK_PER_SEC(CPS), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset_n(reset_n), .add_select(add_select), .set_en(set_en),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .field_sel(field_sel), .sec_pulse(sec_pulse)
  );

  // Reference model: plain integers, time kept as seconds-of-day on rollover.
  int         m_h, m_m, m_s, m_f, m_ticks, m_rc;
  bit         m_long, m_pulse;
  logic [2:0] m_prev;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bump(input int f);
    case (f)
      1: m_s = (m_s + 1) % 60;
      2: m_m = (m_m + 1) % 60;
      3: m_h = (m_h + 1) % 24;
      default: ;
    endcase
  endtask

  task automatic model_step(input bit r, input logic [2:0] a, input bit s);
    logic [2:0] ev;
    int t;
    if (!r) begin
      m_h = 0; m_m = 0; m_s = 0; m_f = 0; m_ticks = 0; m_rc = 0;
      m_long = 0; m_pulse = 0; m_prev = 3'b000;
      return;
    end
    m_pulse = 0;
    ev = (a == 3'b001 || a == 3'b010 || a == 3'b100) ? (a & ~m_prev) : 3'b000;
    if (m_f == 0) begin
      m_long = 0;
      if (s) begin
        m_f = 2; m_ticks = 0;
      end else begin
        m_ticks++;
        if (m_ticks == CPS) begin
          m_ticks = 0; m_pulse = 1;
          t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
        end
      end
    end else if (!s) begin
      m_f = 0; m_ticks = 0; m_long = 0;
    end else begin
      if (ev == 3'b010) m_f = (m_f == 2) ? 3 : (m_f == 3) ? 1 : 2;
      else if (ev == 3'b001) bump(m_f);
      else if (ev == 3'b100) begin bump(m_f); m_long = 1; m_rc = 0; end
      else if (m_long && a == 3'b100) begin
        m_rc++;
        if (m_rc == REP) begin bump(m_f); m_rc = 0; end
      end
      if (a != 3'b100) m_long = 0;
    end
    m_prev = a;
  endtask

  task automatic tick(input bit r, input logic [2:0] a, input bit s);
    reset_n = r; add_select = a; set_en = s;
    @(posedge clk); #1;
    model_step(r, a, s);
    chk("model", 32'({hour_bcd, min_bcd, sec_bcd, field_sel, sec_pulse}),
        32'({to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 2'(m_f), m_pulse}));
  endtask

  task automatic press(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1, 3'b001, 1);
      tick(1, 3'b000, 1);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] add;
    bit         sen;
    logic [7:0] h, m, s;
    logic [1:0] f;
    bit         p;
  } vec_t;

  vec_t tbl[21];
  logic [2:0] codes[8];

  initial begin
    int first, npulse;
    bit s_r;
    logic [2:0] a_r;

    // Table: reset, set minutes, long press on hours (cycles 1 and 5),
    // illegal code, field rotation, exit and press-on-entry collision.
    tbl[0]  = '{0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 2'd0, 0};
    tbl[1]  = '{1, 3'b000, 1, 8'h00, 8'h00, 8'h00, 2'd2, 0};
    tbl[2]  = '{1, 3'b001, 1, 8'h00, 8'h01, 8'h00, 2'd2, 0};
    tbl[3]  = '{1, 3'b000, 1, 8'h00, 8'h01, 8'h00, 2'd2, 0};
    tbl[4]  = '{1, 3'b001, 1, 8'h00, 8'h02, 8'h00, 2'd2, 0};
    tbl[5]  = '{1, 3'b000, 1, 8'h00, 8'h02, 8'h00, 2'd2, 0};
    tbl[6]  = '{1, 3'b010, 1, 8'h00, 8'h02, 8'h00, 2'd3, 0};
    tbl[7]  = '{1, 3'b000, 1, 8'h00, 8'h02, 8'h00, 2'd3, 0};
    tbl[8]  = '{1, 3'b100, 1, 8'h01, 8'h02, 8'h00, 2'd3, 0};
    tbl[9]  = '{1, 3'b100, 1, 8'h01, 8'h02, 8'h00, 2'd3, 0};
    tbl[10] = '{1, 3'b100, 1, 8'h01, 8'h02, 8'h00, 2'd3, 0};
    tbl[11] = '{1, 3'b100, 1, 8'h01, 8'h02, 8'h00, 2'd3, 0};
    tbl[12] = '{1, 3'b100, 1, 8'h02, 8'h02, 8'h00, 2'd3, 0};
    tbl[13] = '{1, 3'b000, 1, 8'h02, 8'h02, 8'h00, 2'd3, 0};
    tbl[14] = '{1, 3'b011, 1, 8'h02, 8'h02, 8'h00, 2'd3, 0};
    tbl[15] = '{1, 3'b000, 1, 8'h02, 8'h02, 8'h00, 2'd3, 0};
    tbl[16] = '{1, 3'b010, 1, 8'h02, 8'h02, 8'h00, 2'd1, 0};
    tbl[17] = '{1, 3'b001, 1, 8'h02, 8'h02, 8'h01, 2'd1, 0};
    tbl[18] = '{1, 3'b000, 0, 8'h02, 8'h02, 8'h01, 2'd0, 0};
    tbl[19] = '{1, 3'b001, 1, 8'h02, 8'h02, 8'h01, 2'd2, 0};
    tbl[20] = '{1, 3'b000, 1, 8'h02, 8'h02, 8'h01, 2'd2, 0};

    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].rst, tbl[i].add, tbl[i].sen);
      chk($sformatf("vec%0d", i),
          32'({hour_bcd, min_bcd, sec_bcd, field_sel, sec_pulse}),
          32'({tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].f, tbl[i].p}));
    end

    // Reset then run 600 cycles: 60 pulses, first at cycle 10.
    tick(0, 3'b000, 0);
    first = -1; npulse = 0;
    for (int c = 1; c <= 600; c++) begin
      tick(1, 3'b000, 0);
      if (sec_pulse) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
    chk("first_pulse", 32'(first), 32'd10);
    chk("pulse_count", 32'(npulse), 32'd60);
    chk("run_600", 32'({hour_bcd, min_bcd, sec_bcd}), 32'(24'h000100));

    // Minute wrap without carry, then build 23:59:59.
    tick(1, 3'b000, 1);
    chk("enter_set", 32'(field_sel), 32'd2);
    press(57);
    chk("min58", 32'(min_bcd), 32'h58);
    press(2);
    chk("min_wrap", 32'({hour_bcd, min_bcd}), 32'h0000);
    tick(1, 3'b010, 1);
    chk("to_hour", 32'(field_sel), 32'd3);
    tick(1, 3'b000, 1);
    press(23);
    chk("hour23", 32'(hour_bcd), 32'h23);
    tick(1, 3'b010, 1); tick(1, 3'b000, 1);
    chk("to_sec", 32'(field_sel), 32'd1);
    press(59);
    tick(1, 3'b010, 1); tick(1, 3'b000, 1);
    press(59);
    chk("preset", 32'({hour_bcd, min_bcd, sec_bcd}), 32'(24'h235959));
    tick(1, 3'b000, 0);
    npulse = 0;
    for (int c = 0; c < 9; c++) begin
      tick(1, 3'b000, 0);
      if (sec_pulse) npulse++;
    end
    chk("no_early_pulse", 32'({npulse[7:0], hour_bcd, min_bcd, sec_bcd}), 32'h00235959);
    tick(1, 3'b000, 0);
    chk("full_wrap", 32'({hour_bcd, min_bcd, sec_bcd, 7'd0, sec_pulse}), 32'h00000001);
    tick(1, 3'b000, 0);
    chk("pulse_one_cycle", 32'(sec_pulse), 32'd0);

    // Reset during a held long press; held code ignored until it re-rises.
    tick(1, 3'b000, 1);
    tick(1, 3'b010, 1); tick(1, 3'b000, 1);
    tick(1, 3'b100, 1);
    chk("long_first", 32'(hour_bcd), 32'h01);
    tick(1, 3'b100, 1);
    tick(0, 3'b100, 1);
    chk("mid_reset", 32'({hour_bcd, min_bcd, sec_bcd, field_sel, sec_pulse}), 32'd0);
    tick(1, 3'b100, 1);
    chk("reenter", 32'(field_sel), 32'd2);
    for (int c = 0; c < 8; c++) tick(1, 3'b100, 1);
    chk("held_ignored", 32'({hour_bcd, min_bcd}), 32'h0000);
    tick(1, 3'b000, 1);
    tick(1, 3'b100, 1);
    chk("rerise", 32'(min_bcd), 32'h01);

    // Randomized stimulus against the model.
    codes[0] = 3'b000; codes[1] = 3'b000; codes[2] = 3'b001; codes[3] = 3'b010;
    codes[4] = 3'b100; codes[5] = 3'b100; codes[6] = 3'b011; codes[7] = 3'b110;
    a_r = 3'b000; s_r = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) a_r = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 59) == 0) s_r = ~s_r;
      tick(($urandom_range(0, 299) != 0), a_r, s_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
